pic_tmr0: RTL and testbench



---
 rtl/pic_pkg.sv | 27 ++
 rtl/pic_sync_edge.sv | 40 ++++
 rtl/pic_tmr0.sv | 185 ++++++++++++++++++
 tb/tb_pic_tmr0.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// -----------------------------------------------------------------------------
// pic_pkg
// Shared definitions for the PIC16C55 peripheral blocks.
//   - OPTION register bit positions {T0CS, T0SE, PSA, PS[2:0]}
//   - OPTION reset value
//   - TMR0 write-inhibit count
//   - low_ones(): true when the low 'nbits' bits of an 8-bit value are all ones
// -----------------------------------------------------------------------------
package pic_pkg;

    localparam int OPT_T0CS  = 5;
    localparam int OPT_T0SE  = 4;
    localparam int OPT_PSA   = 3;
    localparam int OPT_PS_HI = 2;
    localparam int OPT_PS_LO = 0;

    localparam logic [5:0] OPTION_RST   = 6'b111111;
    localparam logic [1:0] TMR0_INHIBIT = 2'd2;

    // nbits may range 0..8; nbits = 0 yields an empty mask, which is always "all ones".
    function automatic logic low_ones(input logic [7:0] value, input logic [3:0] nbits);
        logic [7:0] mask;
        mask = 8'((9'h001 << nbits) - 9'h001);
        return ((value & mask) == mask);
    endfunction

endpackage

// File: rtl/pic_sync_edge.sv
// -----------------------------------------------------------------------------
// pic_sync_edge
// Synchronises an asynchronous pin into the clk domain and flags its edges.
// Ports:
//   clk    in  core clock
//   rst_n  in  asynchronous active-low reset
//   din    in  asynchronous input pin
//   rise   out high for one clk after a synchronised 0->1 transition
//   fall   out high for one clk after a synchronised 1->0 transition
// A transition first sampled at edge k is visible on rise/fall between edges
// k+STAGES-1 and k+STAGES, so a consumer registering it acts at edge k+STAGES.
// -----------------------------------------------------------------------------
module pic_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              prev_r;

    // Synchroniser chain plus one flop holding the previous synchronised level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], din};
            prev_r <= sync_r[STAGES-1];
        end
    end

    assign rise = sync_r[STAGES-1] & ~prev_r;
    assign fall = ~sync_r[STAGES-1] & prev_r;

endmodule

// File: rtl/pic_tmr0.sv
// -----------------------------------------------------------------------------
// pic_tmr0
// Timer0 (RTCC) with an 8-bit prescaler shared between TMR0 and the watchdog.
// Ports:
//   clk, rst_n        core clock, asynchronous active-low reset
//   cyc_en            instruction-cycle strobe (internal tick source)
//   t0cki             external Timer0 clock pin (asynchronous)
//   option_we/_din    OPTION write {T0CS, T0SE, PSA, PS[2:0]}
//   tmr0_we/_din      TMR0 write
//   clrwdt            CLRWDT strobe (clears prescaler when assigned to WDT)
//   wdt_tick          WDT oscillator tick
//   tmr0_q, option_q  register read-back
//   tmr0_ovf          one-clk pulse, high while tmr0_q first reads 00 after FF
//   wdt_ps_out        prescaled WDT tick
// Optional feature, macro TMR0_OVF_FLAG_EN:
//   ovf_clr (in), ovf_flag (out) -- sticky overflow flag, set beats clear.
// -----------------------------------------------------------------------------
module pic_tmr0
    import pic_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cyc_en,
    input  logic       t0cki,
    input  logic       option_we,
    input  logic [5:0] option_din,
    input  logic       tmr0_we,
    input  logic [7:0] tmr0_din,
    input  logic       clrwdt,
    input  logic       wdt_tick,
    output logic [7:0] tmr0_q,
    output logic [5:0] option_q,
    output logic       tmr0_ovf,
    output logic       wdt_ps_out
`ifdef TMR0_OVF_FLAG_EN
    ,
    input  logic       ovf_clr,
    output logic       ovf_flag
`endif
);

    logic [5:0] option_r;
    logic [7:0] pre_r;
    logic [7:0] tmr0_r;
    logic [1:0] inhibit_r;
    logic       tmr0_ovf_r;
    logic       wdt_ps_out_r;

    logic       rise_s;
    logic       fall_s;
    logic       tick_s;
    logic       tmr_evt_s;
    logic       pre_inc_s;
    logic       pre_clr_s;
    logic       wdt_ps_s;
    logic [3:0] ps_s;

    pic_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (t0cki),
        .rise  (rise_s),
        .fall  (fall_s)
    );

    // Tick source selection and prescaler routing, always from the current OPTION.
    always_comb begin
        tick_s    = 1'b0;
        tmr_evt_s = 1'b0;
        pre_inc_s = 1'b0;
        wdt_ps_s  = 1'b0;
        ps_s      = {1'b0, option_r[OPT_PS_HI:OPT_PS_LO]};

        if (option_r[OPT_T0CS]) begin
            if (option_r[OPT_T0SE]) begin
                tick_s = fall_s;
            end else begin
                tick_s = rise_s;
            end
        end else begin
            tick_s = cyc_en;
        end

        if (option_r[OPT_PSA]) begin
            // Prescaler on WDT: 1:2^PS, PS=0 passes every tick.
            tmr_evt_s = tick_s;
            pre_inc_s = wdt_tick;
            wdt_ps_s  = wdt_tick & low_ones(pre_r, ps_s);
        end else begin
            // Prescaler on TMR0: 1:2^(PS+1).
            tmr_evt_s = tick_s & low_ones(pre_r, ps_s + 4'd1);
            pre_inc_s = tick_s;
            wdt_ps_s  = wdt_tick;
        end

        pre_clr_s = option_we
                  | (tmr0_we & ~option_r[OPT_PSA])
                  | (clrwdt  &  option_r[OPT_PSA]);
    end

    // OPTION register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            option_r <= OPTION_RST;
        end else if (option_we) begin
            option_r <= option_din;
        end else begin
            option_r <= option_r;
        end
    end

    // Shared prescaler; a clear overrides a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_r <= 8'h00;
        end else if (pre_clr_s) begin
            pre_r <= 8'h00;
        end else if (pre_inc_s) begin
            pre_r <= pre_r + 8'd1;
        end else begin
            pre_r <= pre_r;
        end
    end

    // TMR0 counter, write inhibit and overflow pulse; a write beats an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr0_r     <= 8'h00;
            inhibit_r  <= 2'd0;
            tmr0_ovf_r <= 1'b0;
        end else if (tmr0_we) begin
            tmr0_r     <= tmr0_din;
            inhibit_r  <= TMR0_INHIBIT;
            tmr0_ovf_r <= 1'b0;
        end else if (tmr_evt_s) begin
            if (inhibit_r != 2'd0) begin
                inhibit_r  <= inhibit_r - 2'd1;
                tmr0_ovf_r <= 1'b0;
            end else begin
                tmr0_r     <= tmr0_r + 8'd1;
                tmr0_ovf_r <= (tmr0_r == 8'hFF);
            end
        end else begin
            tmr0_ovf_r <= 1'b0;
        end
    end

    // Registered prescaled watchdog tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_ps_out_r <= 1'b0;
        end else begin
            wdt_ps_out_r <= wdt_ps_s;
        end
    end

`ifdef TMR0_OVF_FLAG_EN
    logic ovf_flag_r;

    // Sticky overflow flag; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_flag_r <= 1'b0;
        end else if (tmr0_ovf_r) begin
            ovf_flag_r <= 1'b1;
        end else if (ovf_clr) begin
            ovf_flag_r <= 1'b0;
        end else begin
            ovf_flag_r <= ovf_flag_r;
        end
    end

    assign ovf_flag = ovf_flag_r;
`endif

    assign tmr0_q     = tmr0_r;
    assign option_q   = option_r;
    assign tmr0_ovf   = tmr0_ovf_r;
    assign wdt_ps_out = wdt_ps_out_r;

endmodule

// File: tb/tb_pic_tmr0.sv
// -----------------------------------------------------------------------------
// tb_pic_tmr0
// Directed scenarios plus a randomized phase, compared every cycle against a
// behavioural model built from counts and modulo arithmetic.
// -----------------------------------------------------------------------------
module tb_pic_tmr0;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cyc_en = 1'b0;
    logic       t0cki = 1'b0;
    logic       option_we = 1'b0;
    logic [5:0] option_din = 6'd0;
    logic       tmr0_we = 1'b0;
    logic [7:0] tmr0_din = 8'd0;
    logic       clrwdt = 1'b0;
    logic       wdt_tick = 1'b0;
    logic [7:0] tmr0_q;
    logic [5:0] option_q;
    logic       tmr0_ovf;
    logic       wdt_ps_out;
`ifdef TMR0_OVF_FLAG_EN
    logic       ovf_clr = 1'b0;
    logic       ovf_flag;
`endif

    always #5 clk = ~clk;

    pic_tmr0 #(.SYNC_STAGES(SYNC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cyc_en     (cyc_en),
        .t0cki      (t0cki),
        .option_we  (option_we),
        .option_din (option_din),
        .tmr0_we    (tmr0_we),
        .tmr0_din   (tmr0_din),
        .clrwdt     (clrwdt),
        .wdt_tick   (wdt_tick),
        .tmr0_q     (tmr0_q),
        .option_q   (option_q),
        .tmr0_ovf   (tmr0_ovf),
        .wdt_ps_out (wdt_ps_out)
`ifdef TMR0_OVF_FLAG_EN
        ,
        .ovf_clr    (ovf_clr),
        .ovf_flag   (ovf_flag)
`endif
    );

    // Reference model state
    int         m_tmr, m_pre, m_inh;
    logic [5:0] m_opt;
    bit         m_ovf, m_wps, m_flag;
    bit         hist [0:SYNC+1];   // hist[0] = t0cki sampled at the previous edge

    int n_checks = 0;
    int n_pass   = 0;
    int ovf_seen = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_tmr = 0; m_pre = 0; m_inh = 0; m_opt = 6'h3F;
        m_ovf = 1'b0; m_wps = 1'b0; m_flag = 1'b0;
        for (int i = 0; i <= SYNC + 1; i++) hist[i] = 1'b0;
    endtask

    // One clock edge of the specified behaviour, using the inputs present at the edge.
    task automatic model_step();
        bit t0cs, t0se, psa, cur, old, tick, inc, wps, clr;
        int ps, div, wdiv;
        t0cs = m_opt[5]; t0se = m_opt[4]; psa = m_opt[3]; ps = int'(m_opt[2:0]);
        cur  = hist[SYNC-1]; old = hist[SYNC];
        if (t0cs) tick = t0se ? (old && !cur) : (cur && !old);
        else      tick = cyc_en;
        div  = 1 << (ps + 1);
        wdiv = 1 << ps;
        if (!psa) begin
            inc = tick && ((m_pre % div) == div - 1);
            wps = wdt_tick;
        end else begin
            inc = tick;
            wps = wdt_tick && ((m_pre % wdiv) == wdiv - 1);
        end
`ifdef TMR0_OVF_FLAG_EN
        if (m_ovf) m_flag = 1'b1;
        else if (ovf_clr) m_flag = 1'b0;
`endif
        clr = option_we || (tmr0_we && !psa) || (clrwdt && psa);
        if (clr) m_pre = 0;
        else if (psa ? wdt_tick : tick) m_pre = (m_pre + 1) % 256;
        m_ovf = 1'b0;
        if (tmr0_we) begin
            m_tmr = int'(tmr0_din);
            m_inh = 2;
        end else if (inc) begin
            if (m_inh > 0) m_inh--;
            else begin
                if (m_tmr == 255) m_ovf = 1'b1;
                m_tmr = (m_tmr + 1) % 256;
            end
        end
        m_wps = wps;
        if (option_we) m_opt = option_din;
        for (int i = SYNC + 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = t0cki;
    endtask

    // Advance one clock, compare outputs on the falling edge, drop one-shot strobes.
    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        chk("tmr0_q",     32'(tmr0_q),     32'(m_tmr));
        chk("option_q",   32'(option_q),   32'(m_opt));
        chk("tmr0_ovf",   32'(tmr0_ovf),   32'(m_ovf));
        chk("wdt_ps_out", 32'(wdt_ps_out), 32'(m_wps));
`ifdef TMR0_OVF_FLAG_EN
        chk("ovf_flag",   32'(ovf_flag),   32'(m_flag));
        ovf_clr = 1'b0;
`endif
        if (tmr0_ovf) ovf_seen++;
        cyc_en = 1'b0; option_we = 1'b0; tmr0_we = 1'b0; clrwdt = 1'b0; wdt_tick = 1'b0;
    endtask

    task automatic wr_opt(input logic [5:0] v);
        option_din = v; option_we = 1'b1; cycle();
    endtask

    task automatic wr_tmr(input logic [7:0] v);
        tmr0_din = v; tmr0_we = 1'b1; cycle();
    endtask

    task automatic strobe(input int gap);
        cyc_en = 1'b1; cycle();
        repeat (gap - 1) cycle();
    endtask

    initial begin
        int ovf_at, p_cnt, p_first, p_second;
        logic [7:0] exp_c [4];

        // Reset
        #1 rst_n = 1'b0;
        model_reset();
        repeat (2) cycle();
        chk("rst_tmr0", 32'(tmr0_q), 32'h00);
        chk("rst_option", 32'(option_q), 32'h3F);
        rst_n = 1'b1;

        // Internal clock, no prescale: 300 strobes every 4th clk
        wr_opt(6'b001000);
        ovf_seen = 0; ovf_at = 0;
        for (int i = 1; i <= 300; i++) begin
            cyc_en = 1'b1; cycle();
            if (tmr0_ovf) ovf_at = i;
            repeat (3) cycle();
        end
        chk("A_tmr0", 32'(tmr0_q), 32'h2C);
        chk("A_ovf_cnt", 32'(ovf_seen), 32'd1);
        chk("A_ovf_at", 32'(ovf_at), 32'd256);

        // PS=2 on TMR0, then a mid-run OPTION write restarts the prescaler
        wr_tmr(8'h00);
        repeat (2) strobe(2);
        wr_opt(6'b000010);
        repeat (64) strobe(2);
        chk("B_tmr0_64", 32'(tmr0_q), 32'h08);
        repeat (4) strobe(2);
        wr_opt(6'b000010);
        repeat (7) strobe(2);
        chk("B_after7", 32'(tmr0_q), 32'h08);
        strobe(2);
        chk("B_after8", 32'(tmr0_q), 32'h09);

        // Write inhibit
        wr_opt(6'b001000);
        wr_tmr(8'hFE);
        ovf_seen = 0;
        exp_c[0] = 8'hFE; exp_c[1] = 8'hFE; exp_c[2] = 8'hFF; exp_c[3] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            strobe(2);
            chk("C_inhibit", 32'(tmr0_q), 32'(exp_c[i]));
        end
        chk("C_ovf_cnt", 32'(ovf_seen), 32'd1);

        // External falling-edge clock, latency SYNC clocks after first sample
        wr_tmr(8'h00);
        repeat (2) strobe(2);
        wr_opt(6'b111000);
        for (int p = 0; p < 5; p++) begin
            t0cki = 1'b1; repeat (3) cycle();
            t0cki = 1'b0;
            cycle(); chk("D_edge_k",  32'(tmr0_q), 32'(p));
            cycle(); chk("D_edge_k1", 32'(tmr0_q), 32'(p));
            cycle(); chk("D_edge_k2", 32'(tmr0_q), 32'(p + 1));
        end
        chk("D_tmr0", 32'(tmr0_q), 32'h05);

        // WDT prescale PS=3, CLRWDT after tick 10
        wr_opt(6'b001011);
        p_cnt = 0; p_first = 0; p_second = 0;
        for (int t = 1; t <= 20; t++) begin
            wdt_tick = 1'b1; cycle();
            if (wdt_ps_out) begin
                p_cnt++;
                if (p_cnt == 1) p_first = t;
                else p_second = t;
            end
            if (t == 10) clrwdt = 1'b1;
            cycle();
        end
        chk("E_pulses", 32'(p_cnt), 32'd2);
        chk("E_first", 32'(p_first), 32'd8);
        chk("E_second", 32'(p_second), 32'd18);

`ifdef TMR0_OVF_FLAG_EN
        chk("F_flag_held", 32'(ovf_flag), 32'd1);
        ovf_clr = 1'b1; cycle();
        chk("F_flag_clr", 32'(ovf_flag), 32'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cyc_en     = ($urandom_range(0, 3) == 0);
            wdt_tick   = ($urandom_range(0, 7) == 0);
            clrwdt     = ($urandom_range(0, 31) == 0);
            option_we  = ($urandom_range(0, 63) == 0);
            option_din = 6'($urandom);
            tmr0_we    = ($urandom_range(0, 47) == 0);
            tmr0_din   = 8'($urandom);
            if ($urandom_range(0, 3) == 0) t0cki = ~t0cki;
`ifdef TMR0_OVF_FLAG_EN
            ovf_clr    = ($urandom_range(0, 15) == 0);
`endif
            cycle();
        end

        // Asynchronous reset mid-count
        wr_opt(6'b001000);
        wr_tmr(8'h5A);
        wdt_tick = 1'b1; cycle();
        chk("R_pre_wdt", 32'(wdt_ps_out), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("R_tmr0", 32'(tmr0_q), 32'h00);
        chk("R_option", 32'(option_q), 32'h3F);
        chk("R_wdt_ps", 32'(wdt_ps_out), 32'd0);
        chk("R_ovf", 32'(tmr0_ovf), 32'd0);
        model_reset();
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cyc_en = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 2) == 0) t0cki = ~t0cki;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
